// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter running on the oversampled RX clock.
// Each serial bit is held for `prescale` clock cycles. A frame is start bit,
// DATA_WIDTH data bits LSB first, an optional parity bit, then the stop bit(s).
// Build option: define UART_TX_TWO_STOP_EN for two stop bits per frame.
// TX_OUT and busy are flops decoded from the current state, so they follow
// the FSM by one cycle: a byte accepted on edge N drives the start bit from N+1.
`timescale 1ns/1ps

module uart_tx_core #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      TX_OUT,
  output logic                      busy
);

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [BIT_CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0]     shreg;
  logic                      par_en_q;
  logic                      par_bit_q;
  logic                      edge_last;
  logic                      tx_next;

  // Bit boundary: last cycle of the current bit. P of 0 or 1 means one cycle per bit.
  assign edge_last = (prescale_q <= PRESCALE_WIDTH'(1)) ||
                     (edge_cnt == prescale_q - PRESCALE_WIDTH'(1));

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and line-level decode for the current state.
  // NOTE: defaults are assigned first so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_next = state;
    tx_next    = 1'b1;
    case (state)
      IDLE: begin
        if (DATA_VALID) state_next = START;
      end
      START: begin
        tx_next = 1'b0;
        if (edge_last) state_next = DATA;
      end
      DATA: begin
        tx_next = shreg[0];
        if (edge_last && (bit_cnt == LAST_DATA))
          state_next = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        tx_next = par_bit_q;
        if (edge_last) state_next = STOP;
      end
      STOP: begin
        if (edge_last && (bit_cnt == LAST_STOP)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame datapath: latch the request in IDLE, then count cycles and bits.
  // NOTE: every datapath flop, the shift register included, is cleared by the
  // async reset so an abandoned frame leaves nothing behind.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
    end else if (state == IDLE) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
      if (DATA_VALID) begin
        shreg      <= P_DATA;
        par_bit_q  <= (^P_DATA) ^ PAR_TYP;
        par_en_q   <= PAR_EN;
        prescale_q <= prescale;
      end
    end else if (edge_last) begin
      edge_cnt <= '0;
      if (state == DATA) begin
        shreg   <= shreg >> 1;
        bit_cnt <= (bit_cnt == LAST_DATA) ? '0 : bit_cnt + BIT_CNT_W'(1);
      end else if (state == STOP) begin
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end
    end else begin
      edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
    end
  end

  // Output flops: glitch-free line and busy flag, idle-high out of reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      TX_OUT <= 1'b1;
      busy   <= 1'b0;
    end else begin
      TX_OUT <= tx_next;
      busy   <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed bench for uart_tx_core. Expected frames are written
// as bit strings in transmission order (start, data LSB first, parity, stop).
// Honours UART_TX_TWO_STOP_EN for the stop-bit count.
`timescale 1ns/1ps

module tb_uart_tx_core;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic       TX_OUT;
  logic       busy;

  int checks = 0;
  int errors = 0;

`ifdef UART_TX_TWO_STOP_EN
  string stop_str = "11";
`else
  string stop_str = "1";
`endif

  uart_tx_core #(
    .DATA_WIDTH     (8),
    .PRESCALE_WIDTH (6)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .prescale   (prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Present a request for one edge (or keep it asserted when hold=1).
  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic [5:0] p, input logic hold);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    prescale   = p;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = hold;
    check("accept_tx", TX_OUT, 1'b1);
    check("accept_busy", busy, 1'b0);
  endtask

  // Check every cycle of a frame, then the idle-high gap cycle after it.
  task automatic check_frame(input string tag, input string bits, input int p,
                             input bit disturb, input logic hold,
                             input logic [7:0] next_data);
    int n = bits.len() * p;
    for (int c = 0; c < n; c++) begin
      @(negedge CLK);
      check({tag, "_tx"}, TX_OUT, bits[c / p] == "1");
      check({tag, "_busy"}, busy, 1'b1);
      if (disturb && c >= p && c < 9 * p) begin
        P_DATA     = 8'hFF;
        DATA_VALID = (c % 2 == 1);
        PAR_EN     = ~PAR_EN;
        prescale   = 6'd3;
      end
      if (disturb && c == 9 * p) DATA_VALID = 1'b0;
      if (c == n - 1) begin
        DATA_VALID = hold;
        P_DATA     = next_data;
      end
    end
    @(negedge CLK);
    check({tag, "_gap_tx"}, TX_OUT, 1'b1);
    check({tag, "_gap_busy"}, busy, 1'b0);
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge CLK);
      check({tag, "_tx"}, TX_OUT, 1'b1);
      check({tag, "_busy"}, busy, 1'b0);
    end
  endtask

  initial begin
    // Asynchronous reset: outputs settle before any clock edge.
    #2 RST = 1'b0;
    #1;
    check("reset_tx", TX_OUT, 1'b1);
    check("reset_busy", busy, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    idle_check("post_reset_idle", 2);

    // 0xA5, no parity, P=8: 0,10100101,1.
    start_frame(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0);
    check_frame("a5", {"0", "10100101", stop_str}, 8, 1'b0, 1'b0, 8'h00);

    // 0x07 even parity, P=16: three ones -> parity 1.
    start_frame(8'h07, 1'b1, 1'b0, 6'd16, 1'b0);
    check_frame("even", {"0", "11100000", "1", stop_str}, 16, 1'b0, 1'b0, 8'h00);

    // 0x07 odd parity: parity 0.
    start_frame(8'h07, 1'b1, 1'b1, 6'd16, 1'b0);
    check_frame("odd", {"0", "11100000", "0", stop_str}, 16, 1'b0, 1'b0, 8'h00);

    // 0x3C with inputs disturbed during DATA: frame unchanged, no extra frame.
    start_frame(8'h3C, 1'b0, 1'b0, 6'd8, 1'b0);
    check_frame("frozen", {"0", "00111100", stop_str}, 8, 1'b1, 1'b0, 8'h00);
    idle_check("frozen_idle", 3);

    // DATA_VALID held high: 0x55 then 0xAA with a single idle-high cycle.
    start_frame(8'h55, 1'b0, 1'b0, 6'd8, 1'b1);
    check_frame("cont1", {"0", "10101010", stop_str}, 8, 1'b0, 1'b1, 8'hAA);
    check_frame("cont2", {"0", "01010101", stop_str}, 8, 1'b0, 1'b0, 8'h00);
    idle_check("cont_idle", 2);

    // prescale=0 behaves as one cycle per bit.
    start_frame(8'h3C, 1'b0, 1'b0, 6'd0, 1'b0);
    check_frame("p0", {"0", "00111100", stop_str}, 1, 1'b0, 1'b0, 8'h00);

    // Reset during data bit 3 of 0xA5 (bit 3 = 0), between clock edges.
    start_frame(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0);
    for (int c = 0; c < 36; c++) @(negedge CLK);
    check("pre_reset_tx", TX_OUT, 1'b0);
    check("pre_reset_busy", busy, 1'b1);
    #2 RST = 1'b0;
    #1;
    check("mid_reset_tx", TX_OUT, 1'b1);
    check("mid_reset_busy", busy, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    idle_check("after_abort_idle", 2);

    // Clean frame after recovery: 0x96 odd parity (four ones -> parity 1).
    start_frame(8'h96, 1'b1, 1'b1, 6'd8, 1'b0);
    check_frame("recover", {"0", "01101001", "1", stop_str}, 8, 1'b0, 1'b0, 8'h00);
    idle_check("final_idle", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
